// File: rtl/alu_cmd_sequencer.sv
// Command sequencer in front of the registered ALU: issues one operand/function
// command at a time, waits out the ALU latency, captures the selected result.
module alu_cmd_sequencer #(
  parameter int IN_DATA_WIDTH = 16,
  parameter int OP_DATA_WIDTH = 32,
  parameter int CNT_WIDTH     = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [IN_DATA_WIDTH-1:0] cmd_a,
  input  logic [IN_DATA_WIDTH-1:0] cmd_b,
  input  logic [3:0]               cmd_fun,
  output logic [IN_DATA_WIDTH-1:0] alu_a,
  output logic [IN_DATA_WIDTH-1:0] alu_b,
  output logic [3:0]               alu_fun,
  input  logic [OP_DATA_WIDTH-1:0] alu_arith_out,
  input  logic                     alu_carry_out,
  input  logic [IN_DATA_WIDTH-1:0] alu_logic_out,
  input  logic [IN_DATA_WIDTH-1:0] alu_cmp_out,
  input  logic [IN_DATA_WIDTH-1:0] alu_shift_out,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [OP_DATA_WIDTH-1:0] rsp_data,
  output logic                     rsp_carry,
  output logic [3:0]               rsp_fun,
  output logic [CNT_WIDTH-1:0]     rsp_count
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

  state_t state, state_d;
  logic   accept, capture, rsp_hs;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_d;
  end

  always_comb begin
    state_d = state;
    accept  = 1'b0;
    capture = 1'b0;
    rsp_hs  = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_ready && cmd_valid) begin
          accept  = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE:   state_d = CAPTURE;
      CAPTURE: begin
        capture = 1'b1;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_valid && rsp_ready) begin
          rsp_hs  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake flags are registered from the next state, so cmd_ready only
  // rises on the first edge after reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
    end else begin
      cmd_ready <= (state_d == IDLE);
      rsp_valid <= (state_d == RESP);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_a   <= '0;
      alu_b   <= '0;
      alu_fun <= '0;
    end else if (accept) begin
      alu_a   <= cmd_a;
      alu_b   <= cmd_b;
      alu_fun <= cmd_fun;
    end
  end

  // Result class is alu_fun[3:2]; only the arithmetic block reports carry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_data  <= '0;
      rsp_carry <= 1'b0;
      rsp_fun   <= '0;
    end else if (capture) begin
      rsp_fun <= alu_fun;
      case (alu_fun[3:2])
        2'b00: begin
          rsp_data  <= alu_arith_out;
          rsp_carry <= alu_carry_out;
        end
        2'b01: begin
          rsp_data  <= OP_DATA_WIDTH'(alu_logic_out);
          rsp_carry <= 1'b0;
        end
        2'b10: begin
          rsp_data  <= OP_DATA_WIDTH'(alu_cmp_out);
          rsp_carry <= 1'b0;
        end
        default: begin
          rsp_data  <= OP_DATA_WIDTH'(alu_shift_out);
          rsp_carry <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        rsp_count <= '0;
    else if (rsp_hs) rsp_count <= rsp_count + CNT_WIDTH'(1);
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: a registered ALU model drives the result inputs,
// a per-command reference predicts response contents, timing and count.
module tb_alu_cmd_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready;
  logic [15:0] cmd_a, cmd_b;
  logic [3:0]  cmd_fun;
  logic [15:0] alu_a, alu_b;
  logic [3:0]  alu_fun;
  logic [31:0] alu_arith_out;
  logic        alu_carry_out;
  logic [15:0] alu_logic_out, alu_cmp_out, alu_shift_out;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_carry;
  logic [3:0]  rsp_fun;
  logic [7:0]  rsp_count;

  int checks  = 0;
  int errors  = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  alu_cmd_sequencer #(.IN_DATA_WIDTH(16), .OP_DATA_WIDTH(32), .CNT_WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_fun(cmd_fun),
    .alu_a(alu_a), .alu_b(alu_b), .alu_fun(alu_fun),
    .alu_arith_out(alu_arith_out), .alu_carry_out(alu_carry_out),
    .alu_logic_out(alu_logic_out), .alu_cmp_out(alu_cmp_out),
    .alu_shift_out(alu_shift_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_carry(rsp_carry), .rsp_fun(rsp_fun),
    .rsp_count(rsp_count)
  );

  // ALU behaviour: {carry, 32-bit arithmetic result}
  function automatic logic [32:0] f_arith(logic [15:0] a, logic [15:0] b, logic [1:0] op);
    logic [31:0] r;
    logic        c;
    case (op)
      2'd0: begin r = 32'(a) + 32'(b); c = r[16]; end
      2'd1: begin r = 32'(a) - 32'(b); c = (a < b); end
      2'd2: begin r = 32'(a) * 32'(b); c = |r[31:16]; end
      default: begin r = {a, b}; c = a[15]; end
    endcase
    return {c, r};
  endfunction

  function automatic logic [15:0] f_logic(logic [15:0] a, logic [15:0] b, logic [1:0] op);
    case (op)
      2'd0: return a & b;
      2'd1: return a | b;
      2'd2: return a ^ b;
      default: return ~(a & b);
    endcase
  endfunction

  function automatic logic [15:0] f_cmp(logic [15:0] a, logic [15:0] b, logic [1:0] op);
    case (op)
      2'd0: return (a == b) ? 16'hFFFF : 16'h0000;
      2'd1: return (a > b)  ? 16'hFFFF : 16'h0000;
      2'd2: return (a < b)  ? 16'hFFFF : 16'h0000;
      default: return {a[7:0], b[7:0]};
    endcase
  endfunction

  function automatic logic [15:0] f_shift(logic [15:0] a, logic [15:0] b, logic [1:0] op);
    int s;
    s = int'(b[3:0]);
    case (op)
      2'd0: return a << s;
      2'd1: return a >> s;
      2'd2: return 16'($signed(a) >>> s);
      default: return (a << s) | (a >> (16 - s));
    endcase
  endfunction

  // Expected response {carry, data}: class picks the block, narrow results zero-extend
  function automatic logic [32:0] ref_rsp(logic [15:0] a, logic [15:0] b, logic [3:0] f);
    case (f[3:2])
      2'b00: return f_arith(a, b, f[1:0]);
      2'b01: return {17'b0, f_logic(a, b, f[1:0])};
      2'b10: return {17'b0, f_cmp(a, b, f[1:0])};
      default: return {17'b0, f_shift(a, b, f[1:0])};
    endcase
  endfunction

  // One-cycle registered ALU: outputs reflect the operands held at the previous edge
  always @(posedge clk) begin
    {alu_carry_out, alu_arith_out} <= f_arith(alu_a, alu_b, alu_fun[1:0]);
    alu_logic_out <= f_logic(alu_a, alu_b, alu_fun[1:0]);
    alu_cmp_out   <= f_cmp(alu_a, alu_b, alu_fun[1:0]);
    alu_shift_out <= f_shift(alu_a, alu_b, alu_fun[1:0]);
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_cmd(input logic [15:0] a, input logic [15:0] b, input logic [3:0] f,
                         input int stall, input bit pend,
                         input logic [15:0] pa, input logic [15:0] pb, input logic [3:0] pf);
    logic [32:0] e;
    int n;
    e = ref_rsp(a, b, f);
    n = 0;
    while (!cmd_ready && n < 20) begin
      step();
      n++;
    end
    chk("cmd_ready_wait", 64'(cmd_ready), 64'(1));
    cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_fun = f;
    step();
    cmd_valid = 1'b0; cmd_a = 16'($urandom); cmd_b = 16'($urandom); cmd_fun = 4'($urandom);
    chk("alu_a", 64'(alu_a), 64'(a));
    chk("alu_b", 64'(alu_b), 64'(b));
    chk("alu_fun", 64'(alu_fun), 64'(f));
    chk("ready_busy", 64'(cmd_ready), 64'(0));
    step();
    chk("rsp_early", 64'(rsp_valid), 64'(0));
    step();
    chk("rsp_valid", 64'(rsp_valid), 64'(1));
    chk("rsp_data", 64'(rsp_data), 64'(e[31:0]));
    chk("rsp_carry", 64'(rsp_carry), 64'(e[32]));
    chk("rsp_fun", 64'(rsp_fun), 64'(f));
    chk("cnt_pre", 64'(rsp_count), 64'(exp_cnt));
    for (int i = 0; i < stall; i++) begin
      if (pend) begin
        cmd_valid = 1'b1; cmd_a = pa; cmd_b = pb; cmd_fun = pf;
      end
      step();
      chk("stall_valid", 64'(rsp_valid), 64'(1));
      chk("stall_data", 64'(rsp_data), 64'(e[31:0]));
      chk("stall_ready", 64'(cmd_ready), 64'(0));
      chk("stall_alu_a", 64'(alu_a), 64'(a));
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    exp_cnt = (exp_cnt + 1) % 256;
    chk("rsp_clear", 64'(rsp_valid), 64'(0));
    chk("cnt_post", 64'(rsp_count), 64'(exp_cnt));
    chk("ready_back", 64'(cmd_ready), 64'(1));
    chk("data_hold", 64'(rsp_data), 64'(e[31:0]));
  endtask

  initial begin
    rst = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_a = '0; cmd_b = '0; cmd_fun = '0;
    step();
    step();
    chk("rst_cmd_ready", 64'(cmd_ready), 64'(0));
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_alu_a", 64'(alu_a), 64'(0));
    chk("rst_rsp_data", 64'(rsp_data), 64'(0));
    chk("rst_rsp_count", 64'(rsp_count), 64'(0));
    @(negedge clk);
    rst = 1'b1;
    step();
    chk("rel_cmd_ready", 64'(cmd_ready), 64'(1));

    // directed: add, multiply, logic AND
    run_cmd(16'h0003, 16'h0004, 4'b0000, 0, 1'b0, '0, '0, '0);
    chk("add_value", 64'(rsp_data), 64'(32'h0000_0007));
    run_cmd(16'h0100, 16'h0100, 4'b0010, 1, 1'b0, '0, '0, '0);
    chk("mul_value", 64'(rsp_data), 64'(32'h0001_0000));
    run_cmd(16'hF0F0, 16'hFF00, 4'b0100, 0, 1'b0, '0, '0, '0);
    chk("and_value", 64'(rsp_data), 64'(32'h0000_F000));

    // backpressure with a second command pending; it is then accepted
    run_cmd(16'h8001, 16'h7FFF, 4'b1111, 5, 1'b1, 16'hABCD, 16'h0005, 4'b1101);
    run_cmd(16'hABCD, 16'h0005, 4'b1101, 0, 1'b0, '0, '0, '0);

    for (int i = 0; i < 40; i++)
      run_cmd(16'($urandom), 16'($urandom), 4'($urandom), $urandom_range(0, 3), 1'b0, '0, '0, '0);

    // reset during CAPTURE
    cmd_valid = 1'b1; cmd_a = 16'h1234; cmd_b = 16'h4321; cmd_fun = 4'b0001;
    step();
    cmd_valid = 1'b0;
    step();
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("mid_alu_a", 64'(alu_a), 64'(0));
    chk("mid_alu_b", 64'(alu_b), 64'(0));
    chk("mid_alu_fun", 64'(alu_fun), 64'(0));
    chk("mid_rsp_data", 64'(rsp_data), 64'(0));
    chk("mid_rsp_count", 64'(rsp_count), 64'(0));
    @(negedge clk);
    rst = 1'b1;
    exp_cnt = 0;
    step();
    chk("mid_ready", 64'(cmd_ready), 64'(1));
    for (int i = 0; i < 4; i++) begin
      step();
      chk("no_stale_rsp", 64'(rsp_valid), 64'(0));
    end

    // 256 back-to-back commands: counter wraps back to 0
    for (int i = 0; i < 256; i++)
      run_cmd(16'($urandom), 16'($urandom), 4'($urandom), 0, 1'b0, '0, '0, '0);
    chk("wrap_zero", 64'(rsp_count), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
